// File: rtl/ghost_mode_scheduler_if.sv
// ghost_mode_scheduler_if: control pulses in, mode/countdown status out for the ghost mode scheduler
interface ghost_mode_scheduler_if;
   logic       start;
   logic       stop;
   logic       pause;
   logic       sec_tick;
   logic       power_pellet;
   logic       ghost_eaten;
   logic [1:0] mode;
   logic       reverse;
   logic       fright_flash;
   logic [2:0] phase_idx;
   logic [7:0] sec_left;
   logic [1:0] eat_mult;
   modport master (
      output start, stop, pause, sec_tick, power_pellet, ghost_eaten,
      input  mode, reverse, fright_flash, phase_idx, sec_left, eat_mult
   );
   modport slave (
      input  start, stop, pause, sec_tick, power_pellet, ghost_eaten,
      output mode, reverse, fright_flash, phase_idx, sec_left, eat_mult
   );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: scatter/chase schedule with frightened pre-emption; GHOST_FRIGHT_CHAIN_EN adds the eat_mult chain counter
module ghost_mode_scheduler #(
   parameter logic [7:0] SCATTER1_SEC = 8'd7,
   parameter logic [7:0] CHASE1_SEC   = 8'd20,
   parameter logic [7:0] SCATTER2_SEC = 8'd7,
   parameter logic [7:0] CHASE2_SEC   = 8'd20,
   parameter logic [7:0] SCATTER3_SEC = 8'd5,
   parameter logic [7:0] CHASE3_SEC   = 8'd20,
   parameter logic [7:0] SCATTER4_SEC = 8'd5,
   parameter logic [7:0] FRIGHT_SEC   = 8'd6,
   parameter logic [7:0] FLASH_SEC    = 8'd2
) (
   input logic              Clk,
   input logic              Reset_n,
   ghost_mode_scheduler_if.slave g
);
   typedef enum logic [1:0] {IDLE, RUN, FRIGHT} state_t;
   state_t     state, state_nx;
   logic [2:0] phase_nx, saved_phase, saved_phase_nx, adv;
   logic [7:0] left_nx, saved_left, saved_left_nx;
   logic [1:0] mode_nx;
   logic       rev_nx, flash_nx;

   function automatic logic [7:0] dur(input logic [2:0] p);
      return p == 3'd0 ? SCATTER1_SEC : p == 3'd1 ? CHASE1_SEC : p == 3'd2 ? SCATTER2_SEC :
             p == 3'd3 ? CHASE2_SEC : p == 3'd4 ? SCATTER3_SEC : p == 3'd5 ? CHASE3_SEC :
             p == 3'd6 ? SCATTER4_SEC : 8'd0;
   endfunction

   // first phase at or after p with a nonzero duration; phase 7 always lands
   function automatic logic [2:0] land(input logic [2:0] p);
      logic [2:0] n;
      n = p;
      for (int i = 0; i < 7; i++) n = (n != 3'd7 && dur(n) == 8'd0) ? n + 3'd1 : n;
      return n;
   endfunction

   always_comb begin
      state_nx       = state;
      phase_nx       = g.phase_idx;
      left_nx        = g.sec_left;
      saved_phase_nx = saved_phase;
      saved_left_nx  = saved_left;
      rev_nx         = 1'b0;
      adv            = land(g.start ? 3'd0 : g.phase_idx + 3'd1);
      if (g.stop) begin
         state_nx       = IDLE;
         phase_nx       = 3'd0;
         left_nx        = 8'd0;
         saved_phase_nx = 3'd0;
         saved_left_nx  = 8'd0;
      end else if (g.start) begin
         state_nx       = RUN;
         phase_nx       = adv;
         left_nx        = dur(adv);
         saved_phase_nx = 3'd0;
         saved_left_nx  = 8'd0;
      end else if (!g.pause && state == RUN) begin
         if (g.power_pellet && FRIGHT_SEC != 8'd0) begin
            state_nx       = FRIGHT;
            saved_phase_nx = g.phase_idx;
            saved_left_nx  = g.sec_left;
            left_nx        = FRIGHT_SEC;
            rev_nx         = 1'b1;
         end else if (g.sec_tick && g.phase_idx != 3'd7) begin
            left_nx  = g.sec_left > 8'd1 ? g.sec_left - 8'd1 : dur(adv);
            phase_nx = g.sec_left > 8'd1 ? g.phase_idx : adv;
            rev_nx   = g.sec_left <= 8'd1;
         end
      end else if (!g.pause && state == FRIGHT) begin
         if (g.power_pellet) begin
            left_nx = FRIGHT_SEC;
         end else if (g.sec_tick && g.sec_left > 8'd1) begin
            left_nx = g.sec_left - 8'd1;
         end else if (g.sec_tick) begin
            state_nx = RUN;
            phase_nx = saved_phase;
            left_nx  = saved_left;
         end
      end
      mode_nx  = state_nx == IDLE ? 2'd0 : state_nx == FRIGHT ? 2'd3 : phase_nx[0] ? 2'd2 : 2'd1;
      flash_nx = state_nx == FRIGHT && left_nx <= FLASH_SEC && left_nx != 8'd0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state          <= IDLE;
         saved_phase    <= 3'd0;
         saved_left     <= 8'd0;
         g.mode         <= 2'd0;
         g.reverse      <= 1'b0;
         g.fright_flash <= 1'b0;
         g.phase_idx    <= 3'd0;
         g.sec_left     <= 8'd0;
      end else begin
         state          <= state_nx;
         saved_phase    <= saved_phase_nx;
         saved_left     <= saved_left_nx;
         g.mode         <= mode_nx;
         g.reverse      <= rev_nx;
         g.fright_flash <= flash_nx;
         g.phase_idx    <= phase_nx;
         g.sec_left     <= left_nx;
      end
   end

`ifdef GHOST_FRIGHT_CHAIN_EN
   logic [1:0] mult;
   // a pellet that lands in FRIGHT (entry or reload) restarts the chain
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) mult <= 2'd0;
      else if (g.stop || g.start) mult <= 2'd0;
      else if (state_nx == FRIGHT && g.power_pellet && !g.pause) mult <= 2'd0;
      else if (state == FRIGHT && !g.pause && g.ghost_eaten && mult != 2'd3) mult <= mult + 2'd1;
   end
   assign g.eat_mult = mult;
`else
   assign g.eat_mult = 2'd0;
`endif
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: model-compared bench for the ghost mode scheduler, default and FRIGHT_SEC=0 instances
module tb_ghost_mode_scheduler;
   logic Clk = 1'b0, rst_n = 1'b0;
   logic start = 0, stop = 0, pause = 0, sec_tick = 0, power_pellet = 0, ghost_eaten = 0;
   int n_cmp = 0, n_bad = 0;
   always #10 Clk = ~Clk;

   ghost_mode_scheduler_if ifa ();
   ghost_mode_scheduler_if ifb ();
   assign {ifa.start, ifa.stop, ifa.pause, ifa.sec_tick, ifa.power_pellet, ifa.ghost_eaten} =
          {start, stop, pause, sec_tick, power_pellet, ghost_eaten};
   assign {ifb.start, ifb.stop, ifb.pause, ifb.sec_tick, ifb.power_pellet, ifb.ghost_eaten} =
          {start, stop, pause, sec_tick, power_pellet, ghost_eaten};

   ghost_mode_scheduler u_dut (.Clk(Clk), .Reset_n(rst_n), .g(ifa.slave));
   ghost_mode_scheduler #(.FRIGHT_SEC(8'd0)) u_nf (.Clk(Clk), .Reset_n(rst_n), .g(ifb.slave));

   localparam int D[8] = '{7, 20, 7, 20, 5, 20, 5, 0};
   int FS[2] = '{6, 0};
`ifdef GHOST_FRIGHT_CHAIN_EN
   localparam bit CH = 1'b1;
`else
   localparam bit CH = 1'b0;
`endif
   // model: st 0=idle 1=run 2=fright; ph/lf = phase and seconds left; sp/sl = saved context
   int st[2], ph[2], lf[2], sp[2], sl[2], mu[2];
   bit rv[2];

   task automatic step(input int k);
      rv[k] = 0;
      if (stop) begin
         st[k] = 0; ph[k] = 0; lf[k] = 0; sp[k] = 0; sl[k] = 0; mu[k] = 0;
      end else if (start) begin
         st[k] = 1; ph[k] = 0;
         while (ph[k] < 7 && D[ph[k]] == 0) ph[k]++;
         lf[k] = D[ph[k]]; sp[k] = 0; sl[k] = 0; mu[k] = 0;
      end else if (st[k] == 1 && !pause) begin
         if (power_pellet && FS[k] > 0) begin
            sp[k] = ph[k]; sl[k] = lf[k]; st[k] = 2; lf[k] = FS[k]; rv[k] = 1; mu[k] = 0;
         end else if (sec_tick && ph[k] < 7) begin
            if (lf[k] > 1) lf[k]--;
            else begin
               ph[k]++;
               while (ph[k] < 7 && D[ph[k]] == 0) ph[k]++;
               lf[k] = D[ph[k]]; rv[k] = 1;
            end
         end
      end else if (st[k] == 2 && !pause) begin
         if (power_pellet) begin
            lf[k] = FS[k]; mu[k] = 0;
         end else begin
            if (ghost_eaten && CH && mu[k] < 3) mu[k]++;
            if (sec_tick) begin
               lf[k]--;
               if (lf[k] == 0) begin st[k] = 1; ph[k] = sp[k]; lf[k] = sl[k]; end
            end
         end
      end
   endtask

   always @(posedge Clk or negedge rst_n)
      if (!rst_n) for (int k = 0; k < 2; k++) begin
         st[k] = 0; ph[k] = 0; lf[k] = 0; sp[k] = 0; sl[k] = 0; mu[k] = 0; rv[k] = 0;
      end else begin
         step(0);
         step(1);
      end

   function automatic int emode(input int k);
      return st[k] == 0 ? 0 : st[k] == 2 ? 3 : (ph[k] % 2 == 1 ? 2 : 1);
   endfunction
   function automatic int eflash(input int k);
      return (st[k] == 2 && lf[k] <= 2 && lf[k] != 0) ? 1 : 0;
   endfunction

   task automatic cmp(input int k, input int m, r, f, p, s, e);
      n_cmp++;
      if (m != emode(k) || r != int'(rv[k]) || f != eflash(k) || p != ph[k] || s != lf[k] || e != mu[k]) begin
         n_bad++;
         $display("FAIL model dut%0d @%0t: got mode=%0d rev=%0d flash=%0d phase=%0d left=%0d mult=%0d required %0d %0d %0d %0d %0d %0d",
                  k, $time, m, r, f, p, s, e, emode(k), rv[k], eflash(k), ph[k], lf[k], mu[k]);
      end
   endtask

   always @(negedge Clk) if (rst_n) begin
      cmp(0, ifa.mode, ifa.reverse, ifa.fright_flash, ifa.phase_idx, ifa.sec_left, ifa.eat_mult);
      cmp(1, ifb.mode, ifb.reverse, ifb.fright_flash, ifb.phase_idx, ifb.sec_left, ifb.eat_mult);
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", nm, got, exp);
      end
   endtask

   task automatic cyc(input bit s, sp_, pa, tk, pp, ge);
      @(negedge Clk);
      {start, stop, pause, sec_tick, power_pellet, ghost_eaten} = {s, sp_, pa, tk, pp, ge};
   endtask
   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask
   task automatic ticks(input int n);
      repeat (n) cyc(0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      chk("rst mode", ifa.mode, 0); chk("rst rev", ifa.reverse, 0); chk("rst flash", ifa.fright_flash, 0);
      chk("rst phase", ifa.phase_idx, 0); chk("rst left", ifa.sec_left, 0); chk("rst mult", ifa.eat_mult, 0);
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, 0, 0); idle();
      chk("start mode", ifa.mode, 1); chk("start phase", ifa.phase_idx, 0);
      chk("start left", ifa.sec_left, 7); chk("start rev", ifa.reverse, 0);
      ticks(7); idle();
      chk("p1 mode", ifa.mode, 2); chk("p1 phase", ifa.phase_idx, 1);
      chk("p1 left", ifa.sec_left, 20); chk("p1 rev", ifa.reverse, 1);
      idle(); chk("p1 rev drop", ifa.reverse, 0);
      ticks(78); idle();
      chk("p7 phase", ifa.phase_idx, 7); chk("p7 mode", ifa.mode, 2); chk("p7 left", ifa.sec_left, 0);
      ticks(3); idle();
      chk("p7 hold phase", ifa.phase_idx, 7); chk("p7 hold left", ifa.sec_left, 0);
      // asynchronous reset in the middle of a clock period
      cyc(1, 0, 0, 0, 0, 0); ticks(3);
      #5 rst_n = 1'b0;
      #1 chk("async mode", ifa.mode, 0); chk("async left", ifa.sec_left, 0);
      @(negedge Clk); rst_n = 1'b1; sec_tick = 0;
      cyc(1, 0, 0, 0, 0, 0); ticks(15); idle();
      chk("pre-fr left", ifa.sec_left, 12); chk("pre-fr phase", ifa.phase_idx, 1);
      cyc(0, 0, 0, 1, 1, 0); idle();
      chk("fr mode", ifa.mode, 3); chk("fr left", ifa.sec_left, 6); chk("fr rev", ifa.reverse, 1);
      chk("nf mode", ifb.mode, 2); chk("nf left", ifb.sec_left, 11); chk("nf rev", ifb.reverse, 0);
      idle(); chk("fr rev drop", ifa.reverse, 0);
      ticks(4); idle();
      chk("flash left", ifa.sec_left, 2); chk("flash on", ifa.fright_flash, 1);
      ticks(2); idle();
      chk("resume mode", ifa.mode, 2); chk("resume phase", ifa.phase_idx, 1);
      chk("resume left", ifa.sec_left, 12); chk("resume rev", ifa.reverse, 0);
      cyc(0, 0, 0, 0, 1, 0); ticks(4); idle();
      chk("fr2 left", ifa.sec_left, 2);
      cyc(0, 0, 0, 0, 1, 0); idle();
      chk("reload left", ifa.sec_left, 6); chk("reload flash", ifa.fright_flash, 0);
      chk("reload rev", ifa.reverse, 0); chk("reload mode", ifa.mode, 3);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, i != 3, i == 3, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("pause left", ifa.sec_left, 6); chk("pause mode", ifa.mode, 3);
      chk("pause phase", ifa.phase_idx, 1); chk("pause rev", ifa.reverse, 0);
      idle();
      cyc(0, 1, 0, 0, 0, 0); idle();
      chk("stop mode", ifa.mode, 0); chk("stop left", ifa.sec_left, 0); chk("stop nf mode", ifb.mode, 0);
      cyc(1, 0, 0, 0, 0, 0); idle(); chk("restart mode", ifa.mode, 1);
      cyc(1, 1, 0, 0, 0, 0); idle();
      chk("start+stop mode", ifa.mode, 0); chk("start+stop left", ifa.sec_left, 0);
      cyc(1, 0, 0, 0, 0, 0); idle(); cyc(0, 0, 0, 0, 1, 0); idle();
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 0, 1); idle();
         chk("chain mult", ifa.eat_mult, CH ? (i < 3 ? i + 1 : 3) : 0);
      end
      cyc(0, 0, 0, 0, 1, 0); idle();
      chk("chain reset", ifa.eat_mult, 0);
      repeat (2) idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ghost_mode_scheduler.md
Name: ghost_mode_scheduler

Overview:
- Sequences the ghost behaviour mode (scatter / chase / frightened) over a level, driven by the 1-second tick from the game's seconds counter.
- Owns the per-phase countdown and pre-empts the schedule with a frightened interval on power-pellet events, then resumes the interrupted phase with its remaining time intact.
- Sits between the game-state FSM and the ghost AI / sprite palette logic.

Parameters:
- SCATTER1_SEC, 7, duration of phase 0 (scatter)
- CHASE1_SEC, 20, duration of phase 1 (chase)
- SCATTER2_SEC, 7, duration of phase 2 (scatter)
- CHASE2_SEC, 20, duration of phase 3 (chase)
- SCATTER3_SEC, 5, duration of phase 4 (scatter)
- CHASE3_SEC, 20, duration of phase 5 (chase)
- SCATTER4_SEC, 5, duration of phase 6 (scatter); phase 7 is unbounded chase
- FRIGHT_SEC, 6, frightened duration; 0 disables frightened mode
- FLASH_SEC, 2, final seconds of frightened during which fright_flash is high

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin or restart level schedule
- stop  in  1  one-cycle pulse: return to IDLE (level end / game over)
- pause  in  1  level-sensitive freeze (death animation, ready screen)
- sec_tick  in  1  one-cycle pulse per second
- power_pellet  in  1  one-cycle pulse: pellet eaten
- ghost_eaten  in  1  one-cycle pulse: frightened ghost eaten (used only with the optional feature)
- mode  out  2  0=IDLE, 1=SCATTER, 2=CHASE, 3=FRIGHT
- reverse  out  1  one-cycle pulse: ghosts reverse direction
- fright_flash  out  1  frightened interval ending
- phase_idx  out  3  current schedule phase, 0..7
- sec_left  out  8  seconds remaining in the active interval (fright or phase)
- eat_mult  out  2  ghost score multiplier index (optional feature)

Behaviour:
- All outputs are registered. Reset values: mode=0, reverse=0, fright_flash=0, phase_idx=0, sec_left=0, eat_mult=0. Internal saved_phase and saved_left are cleared on reset.
- States are IDLE, RUN (mode 1 or 2, set by the parity of phase_idx: even=SCATTER, odd=CHASE), and FRIGHT.
- IDLE: sec_tick, power_pellet and pause are ignored. On start: phase_idx=0, mode=SCATTER, sec_left=SCATTER1_SEC on the next edge. No reverse is issued.
- start in any state has the same effect as start from IDLE: it restarts at phase 0 and discards any fright and saved context. stop in any state returns to IDLE and clears all outputs to their reset values. If start and stop are asserted together, stop wins.
- RUN, on sec_tick with pause=0:
  - sec_left>1: decrement sec_left.
  - sec_left==1 and phase_idx<7: increment phase_idx, load the next duration, toggle mode, and pulse reverse for exactly the one cycle the new mode is visible.
  - phase_idx==7: sec_left is held at 0 and ticks have no effect.
- A phase whose duration parameter is 0 is skipped on the same edge: advance again, with a single reverse pulse.
- power_pellet with pause=0 and FRIGHT_SEC>0, in RUN: save phase_idx and sec_left, set mode=FRIGHT and sec_left=FRIGHT_SEC, and pulse reverse. A sec_tick in the same cycle is discarded, so the saved value is not decremented.
- FRIGHT, on sec_tick with pause=0: decrement sec_left.
  - When it reaches 0, restore the saved phase_idx and sec_left and the mode from its parity, with no reverse pulse.
  - If the restored phase had saved sec_left==0, meaning phase 7, mode=CHASE.
- power_pellet while in FRIGHT reloads sec_left=FRIGHT_SEC, keeps the saved context and issues no reverse.
- fright_flash = (mode==FRIGHT) && (sec_left<=FLASH_SEC) && (sec_left!=0), registered together with sec_left.
- pause=1 ignores sec_tick and power_pellet. Outputs hold. reverse stays low.
- All durations are 8-bit unsigned with no wrap: sec_left never decrements below 0.

Optional Feature:
- Macro: GHOST_FRIGHT_CHAIN_EN.
- Defined:
  - eat_mult is cleared to 0 on fright entry and on every fright reload.
  - Each ghost_eaten pulse in FRIGHT with pause=0 increments eat_mult, saturating at 3 (200/400/800/1600 points).
  - Outside FRIGHT, ghost_eaten is ignored.
  - eat_mult holds its value after fright ends until the next fright entry.
- Undefined: eat_mult is tied to 0, ghost_eaten is unused, and there is no chain register.

Test Plan:
- Reset low mid-run -> all outputs 0 immediately, asynchronously. Reset release then start -> mode=1, phase_idx=0, sec_left=7, reverse stays 0.
- start, then 7 ticks -> mode=2, phase_idx=1, sec_left=20, reverse high for exactly 1 cycle. Continue 78 more ticks -> phase_idx=7, mode=2, sec_left=0. Further ticks -> no change.
- In phase 1 with sec_left=12, pulse power_pellet together with sec_tick:
  - Response: mode=3, sec_left=6, one reverse pulse.
  - 4 ticks -> fright_flash=1 at sec_left=2. 2 more ticks -> mode=2, phase_idx=1, sec_left=12, no reverse.
- In FRIGHT with sec_left=2, pellet -> sec_left=6, fright_flash=0, no reverse. Hold pause=1 for 5 ticks plus one pellet -> all outputs unchanged.
- With FRIGHT_SEC=0, pellet in RUN -> no state change. stop during FRIGHT -> mode=0. Same-cycle start+stop -> IDLE.
- With GHOST_FRIGHT_CHAIN_EN: pellet, then 5 ghost_eaten pulses -> eat_mult 1, 2, 3, 3, 3. New pellet -> eat_mult=0. Without the macro -> eat_mult=0 throughout.
